// File: rtl/aes_key_expander.sv
// AES-128 key expander: expands CipherKey into 11 round keys held in registers, read back by SelKey.
// Latency: Ry rises 10 edges after the Start capture edge (40 with KEYEXP_SERIAL_SBOX_EN defined).
// Backpressure: none; Start is ignored while Busy, and Key reads as zero until Ry is high.

// Forward AES S-box: GF(2^8) inverse by x^254, followed by the affine transform.
module aes_key_expander_sbox (
    input  logic [7:0] in_dat,
    output logic [7:0] out_dat
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse (and maps 0 to 0).
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x3, x7, x15, x31, x63, x127;
        x3   = gf_mul(gf_mul(x, x), x);
        x7   = gf_mul(gf_mul(x3, x3), x);
        x15  = gf_mul(gf_mul(x7, x7), x);
        x31  = gf_mul(gf_mul(x15, x15), x);
        x63  = gf_mul(gf_mul(x31, x31), x);
        x127 = gf_mul(gf_mul(x63, x63), x);
        return gf_mul(x127, x127);
    endfunction

    logic [7:0] inv;

    // Affine transform expressed as XOR of left rotations plus the 0x63 constant.
    always_comb begin
        inv     = gf_inv(in_dat);
        out_dat = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

module aes_key_expander (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         Start,
    input  logic [127:0] CipherKey,
    input  logic [3:0]   SelKey,
    output logic [127:0] Key,
    output logic         Ry,
    output logic         Busy
);
    typedef enum logic [1:0] {IDLE = 2'd0, EXPAND = 2'd1, DONE = 2'd2} state_t;

    state_t       state_q, state_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [127:0] rk_q [0:10];
    logic [127:0] rk_d [0:10];

    logic [127:0] prev_rk;
    logic [127:0] next_rk;
    logic [31:0]  rot_word;
    logic [31:0]  sub_word;
    logic [31:0]  w4, w5, w6, w7;
    logic         step_en;

    // Source of the current round step: rk[rnd-1].
    always_comb begin
        prev_rk = '0;
        for (int i = 0; i < 10; i++) begin
            if (rnd_q == i[3:0] + 4'd1) prev_rk = rk_q[i];
        end
    end

    // w3 is the least significant word; RotWord moves its top byte to the bottom.
    assign rot_word = {prev_rk[23:0], prev_rk[31:24]};

`ifdef KEYEXP_SERIAL_SBOX_EN
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [23:0] sub_q, sub_d;
    logic [7:0]  sbox_in, sbox_out;

    aes_key_expander_sbox u_sbox (.in_dat(sbox_in), .out_dat(sbox_out));

    // One byte of the rotated word per cycle; the fourth byte completes the word.
    always_comb begin
        sub_d      = sub_q;
        byte_cnt_d = byte_cnt_q;
        case (byte_cnt_q)
            2'd0:    sbox_in = rot_word[7:0];
            2'd1:    sbox_in = rot_word[15:8];
            2'd2:    sbox_in = rot_word[23:16];
            default: sbox_in = rot_word[31:24];
        endcase
        if (state_q == EXPAND) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            case (byte_cnt_q)
                2'd0:    sub_d[7:0]   = sbox_out;
                2'd1:    sub_d[15:8]  = sbox_out;
                2'd2:    sub_d[23:16] = sbox_out;
                default: sub_d        = sub_q;
            endcase
        end else begin
            byte_cnt_d = 2'd0;
        end
    end

    // Byte counter and partial SubWord registers.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            byte_cnt_q <= 2'd0;
            sub_q      <= '0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            sub_q      <= sub_d;
        end
    end

    assign sub_word = {sbox_out, sub_q};
    assign step_en  = (state_q == EXPAND) && (byte_cnt_q == 2'd3);
`else
    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_key_expander_sbox u_sbox (.in_dat(rot_word[8*g +: 8]), .out_dat(sub_word[8*g +: 8]));
    end
    assign step_en = (state_q == EXPAND);
`endif

    assign w4      = prev_rk[127:96] ^ sub_word ^ {rcon_q, 24'h000000};
    assign w5      = prev_rk[95:64] ^ w4;
    assign w6      = prev_rk[63:32] ^ w5;
    assign w7      = prev_rk[31:0] ^ w6;
    assign next_rk = {w4, w5, w6, w7};

    // Next-state logic: capture on Start outside EXPAND, one round key per step.
    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        rcon_d  = rcon_q;
        rk_d    = rk_q;
        case (state_q)
            IDLE, DONE: begin
                if (Start) begin
                    rk_d[0] = CipherKey;
                    rnd_d   = 4'd1;
                    rcon_d  = 8'h01;
                    state_d = EXPAND;
                end
            end
            EXPAND: begin
                if (step_en) begin
                    for (int i = 1; i < 11; i++) begin
                        if (rnd_q == i[3:0]) rk_d[i] = next_rk;
                    end
                    rnd_d  = rnd_q + 4'd1;
                    rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
                    if (rnd_q == 4'd10) state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counters and round-key storage.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
            rnd_q   <= 4'd0;
            rcon_q  <= 8'h01;
            for (int i = 0; i < 11; i++) rk_q[i] <= '0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            rcon_q  <= rcon_d;
            rk_q    <= rk_d;
        end
    end

    assign Busy = (state_q == EXPAND);
    assign Ry   = (state_q == DONE);

    // Round-key read port; zero while not ready or for indices above 10.
    always_comb begin
        Key = '0;
        if (state_q == DONE) begin
            for (int i = 0; i < 11; i++) begin
                if (SelKey == i[3:0]) Key = rk_q[i];
            end
        end
    end
endmodule

// File: tb/tb_aes_key_expander.sv
module tb_aes_key_expander;
`ifdef KEYEXP_SERIAL_SBOX_EN
    localparam int LAT = 40;
`else
    localparam int LAT = 10;
`endif

    logic         Clk;
    logic         Rst;
    logic         Start;
    logic [127:0] CipherKey;
    logic [3:0]   SelKey;
    logic [127:0] Key;
    logic         Ry;
    logic         Busy;

    int n_checks = 0;
    int n_err    = 0;

    logic [7:0]   sbox_tab [0:255];
    logic [127:0] exp_rk [0:10];

    aes_key_expander dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .CipherKey(CipherKey),
        .SelKey(SelKey), .Key(Key), .Ry(Ry), .Busy(Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // S-box table from the generator-3 walk over GF(2^8).
    task automatic init_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        for (int n = 0; n < 255; n++) begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox_tab[p] = x ^ 8'h63;
        end
        sbox_tab[0] = 8'h63;
    endtask

    function automatic logic [7:0] rcon_of(input int r);
        case (r)
            1: return 8'h01;  2: return 8'h02;  3: return 8'h04;  4: return 8'h08;
            5: return 8'h10;  6: return 8'h20;  7: return 8'h40;  8: return 8'h80;
            9: return 8'h1b;  10: return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Word-by-word FIPS-197 key schedule.
    task automatic build_model(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
                t = t ^ {rcon_of(i / 4), 24'h000000};
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic check_all(input string tag);
        for (int r = 0; r < 11; r++) begin
            SelKey = 4'(r);
            #1;
            check($sformatf("%s_rk%0d", tag, r), Key, exp_rk[r]);
        end
    endtask

    // Waits for Ry with a bound; reports edges waited and whether Busy stayed high.
    task automatic wait_ry(output int n, output bit busy_ok);
        n = 0;
        busy_ok = 1'b1;
        while (Ry !== 1'b1 && n < LAT + 20) begin
            if (Busy !== 1'b1) busy_ok = 1'b0;
            tick();
            n++;
        end
    endtask

    task automatic start_pulse(input logic [127:0] k);
        CipherKey = k;
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    task automatic run_random(input string tag);
        logic [127:0] k;
        int n;
        bit bok;
        k = {$urandom, $urandom, $urandom, $urandom};
        build_model(k);
        start_pulse(k);
        wait_ry(n, bok);
        check({tag, "_lat"}, 128'(n), 128'(LAT));
        check_all(tag);
    endtask

    initial begin
        logic [127:0] k1;
        int n;
        bit bok;

        init_sbox();
        Rst = 1'b1;
        Start = 1'b0;
        CipherKey = '0;
        SelKey = 4'd0;
        repeat (2) tick();
        check("rst_ry", 128'(Ry), 128'(0));
        check("rst_busy", 128'(Busy), 128'(0));
        check("rst_key", Key, 128'h0);

        // FIPS-197 vector, Start on the first edge after reset release
        Rst = 1'b0;
        build_model(128'h2b7e151628aed2a6abf7158809cf4f3c);
        start_pulse(128'h2b7e151628aed2a6abf7158809cf4f3c);
        check("cap_busy", 128'(Busy), 128'(1));
        check("cap_ry", 128'(Ry), 128'(0));
        wait_ry(n, bok);
        check("fips_lat", 128'(n), 128'(LAT));
        check("fips_busy_held", 128'(bok), 128'(1));
        SelKey = 4'd1; #1;
        check("fips_rk1", Key, 128'ha0fafe1788542cb123a339392a6c7605);
        SelKey = 4'd10; #1;
        check("fips_rk10", Key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        SelKey = 4'd0; #1;
        check("fips_rk0", Key, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        check_all("fips");

        // Restart from DONE with a new key
        start_pulse(128'h000102030405060708090a0b0c0d0e0f);
        check("restart_ry", 128'(Ry), 128'(0));
        check("restart_busy", 128'(Busy), 128'(1));
        SelKey = 4'd10; #1;
        check("restart_key_zero", Key, 128'h0);
        wait_ry(n, bok);
        check("seq_lat", 128'(n), 128'(LAT));
        SelKey = 4'd10; #1;
        check("seq_rk10", Key, 128'h13111d7fe3944a17f307a78b4d2b30c5);
        for (int s = 11; s < 16; s++) begin
            SelKey = 4'(s); #1;
            check($sformatf("sel%0d_zero", s), Key, 128'h0);
        end

        // Start and key changes during EXPAND are ignored
        k1 = {$urandom, $urandom, $urandom, $urandom};
        build_model(k1);
        start_pulse(k1);
        repeat (3) tick();
        CipherKey = {$urandom, $urandom, $urandom, $urandom};
        Start = 1'b1;
        tick();
        tick();
        Start = 1'b0;
        check("ign_busy", 128'(Busy), 128'(1));
        wait_ry(n, bok);
        check("ign_lat", 128'(n + 5), 128'(LAT));
        check("ign_busy_held", 128'(bok), 128'(1));
        check_all("ign");

        // Asynchronous reset pulse between edges, Start on the first edge after release
        tick();
        #2 Rst = 1'b1;
        SelKey = 4'd0;
        #1;
        check("arst_ry", 128'(Ry), 128'(0));
        check("arst_busy", 128'(Busy), 128'(0));
        check("arst_key", Key, 128'h0);
        #1 Rst = 1'b0;
        run_random("arst");

        // Reset at rnd=5 aborts; block idles until a fresh Start
        start_pulse({$urandom, $urandom, $urandom, $urandom});
        repeat (LAT * 4 / 10) tick();
        #2 Rst = 1'b1;
        #1;
        check("abort_busy", 128'(Busy), 128'(0));
        check("abort_ry", 128'(Ry), 128'(0));
        #1 Rst = 1'b0;
        repeat (3) tick();
        check("idle_busy", 128'(Busy), 128'(0));
        check("idle_ry", 128'(Ry), 128'(0));
        run_random("after_abort");

        for (int i = 0; i < 3; i++) run_random($sformatf("rand%0d", i));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/aes_key_expander.md
AES_KEY_EXPANDER -- requirements
Module: aes_key_expander

Interface
REQ-001 Clk  input  1  single clock; all state updates on rising edge.
REQ-002 Rst  input  1  reset, asynchronous, active-high.
REQ-003 Start  input  1  request a new expansion; sampled on rising Clk edge.
REQ-004 CipherKey  input  128  AES-128 cipher key; bit 127 is byte 0 (FIPS-197 order).
REQ-005 SelKey  input  4  round-key index 0..10, driven by the downstream decryptor.
REQ-006 Key  output  128  round key selected by SelKey.
REQ-007 Ry  output  1  high while all 11 round keys are valid.
REQ-008 Busy  output  1  high while an expansion is in progress.

Function
REQ-009 The FSM SHALL have exactly three states: IDLE, EXPAND and DONE.
REQ-010 In IDLE or DONE, Start=1 SHALL capture CipherKey into rk[0], set round counter rnd=1 and Rcon=0x01, and enter EXPAND.
REQ-011 Each round step SHALL compute w4=w0^T(w3), w5=w1^w4, w6=w2^w5, w7=w3^w6 from rk[rnd-1], where T = RotWord, then SubWord (FIPS-197 forward S-box), then XOR of Rcon into the MSB byte.
REQ-012 After each round step, the block SHALL write rk[rnd], increment rnd, and advance Rcon by xtime (0x80 -> 0x1B).
REQ-013 The write of rk[10] SHALL move the FSM to DONE in the same edge; Ry SHALL be 1 from that edge on.
REQ-014 Busy SHALL equal (state==EXPAND); Ry SHALL equal (state==DONE).
REQ-015 Key SHALL be a combinational read of rk[SelKey] when Ry=1.
REQ-016 Key SHALL be 128'h0 when Ry=0 or SelKey>10.
REQ-017 Start SHALL be ignored while in EXPAND; CipherKey changes after the capture edge SHALL NOT affect results.
REQ-018 Start in DONE SHALL restart expansion: Ry falls and Busy rises on the capture edge.
REQ-019 Round-key storage SHALL be 11 x 128-bit registers with no other read path.

Reset
REQ-020 Rst=1 SHALL asynchronously force state=IDLE, rnd=0, Rcon=0x01, all rk[]=0, Ry=0, Busy=0 and Key=0.
REQ-021 Rst asserted mid-EXPAND SHALL abort the expansion; after release, the block SHALL wait in IDLE for Start.
REQ-022 Start sampled on the first edge after Rst deassertion SHALL be honoured.

Configuration
REQ-023 Macro KEYEXP_SERIAL_SBOX_EN SHALL select the S-box architecture.
REQ-024 Without KEYEXP_SERIAL_SBOX_EN: four S-box instances; one round step per EXPAND cycle; Ry rises on the 10th edge after the capture edge.
REQ-025 With KEYEXP_SERIAL_SBOX_EN: one S-box instance plus a 2-bit byte counter substitute one byte per cycle; one round step every 4 EXPAND cycles; Ry rises on the 40th edge after the capture edge.
REQ-026 Round-key values and all other behaviour SHALL be identical in both builds.

Verification
REQ-027 Rst pulse mid-cycle, no clock -> Ry=0, Busy=0 and Key=0 immediately; Start one edge after release -> expansion proceeds normally.
REQ-028 CipherKey=2b7e151628aed2a6abf7158809cf4f3c, Start pulse -> SelKey=1 gives a0fafe1788542cb123a339392a6c7605; SelKey=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6; SelKey=0 returns the cipher key; Ry at capture+10 edges (+40 edges with the macro).
REQ-029 CipherKey=000102030405060708090a0b0c0d0e0f -> SelKey=10 gives 13111d7fe3944a17f307a78b4d2b30c5; SelKey=11..15 gives 0.
REQ-030 Start re-pulsed and CipherKey changed 3 cycles into EXPAND -> ignored; results match the first key; Busy stays high throughout.
REQ-031 In DONE, Start with a new key -> Ry drops on the capture edge, Key=0 during expansion, new keys valid after the nominal latency.
REQ-032 Rst asserted at rnd=5 -> IDLE; a fresh Start produces correct keys with Rcon sequence restarting at 0x01.
